m_cp0: RTL and testbench

M_CP0 -- requirements
Module: m_cp0

---
 rtl/m_cp0_pkg.sv | 23 ++
 rtl/m_cp0.sv | 130 +++++++++++++
 tb/tb_m_cp0.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/m_cp0_pkg.sv
// Shared CPU constants: CP0 register addresses, exception codes and reset-time defaults.
package m_cp0_pkg;

  // CP0 register select values
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes carried down the pipeline in exc_code_in
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT       = 32'h0042_5541;

  // StInHandler is exactly SR.EXL = 1
  typedef enum logic {StNormal, StInHandler} cp0_state_e;

endpackage

// File: rtl/m_cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception request, EPC capture for eret.
module m_cp0
  import m_cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = PRID_DEFAULT,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] cp0_out,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  cp0_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_target;

  assign exl = (state_q == StInHandler);

  // Requests are combinational so the pipeline can flush in the same cycle; masked during reset
  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl & ~reset;
  assign exc_req = (exc_code_in != EXC_INT) & ~exl & ~reset;
  assign req     = int_req | exc_req;

  assign handler_pc = HANDLER_PC;
  assign epc_target = bd_in ? (vpc - 32'd4) : vpc;

  logic unused_epc_lsb;
  assign unused_epc_lsb = ^epc_target[1:0];

  // Next-state: a taken request overrides any mtc0 write or eret in the same cycle
  always_comb begin
    state_d    = state_q;
    im_d       = im_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      state_d    = StInHandler;
      exc_code_d = int_req ? EXC_INT : exc_code_in;
      bd_d       = bd_in;
      epc_d      = {epc_target[31:2], 2'b00};
    end else begin
      if (we) begin
        case (cp0_addr)
          CP0_SR: begin
            im_d    = cp0_in[15:10];
            ie_d    = cp0_in[0];
            state_d = cp0_in[1] ? StInHandler : StNormal;
          end
          CP0_EPC: epc_d = {cp0_in[31:2], 2'b00};
          default: ;
        endcase
      end
      // eret takes priority over an mtc0 write of EXL in the same cycle
      if (eret) begin
        state_d = StNormal;
      end
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StNormal;
      im_q       <= '0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Cause.IP samples the interrupt lines every cycle regardless of other events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ip_q <= '0;
    end else begin
      ip_q <= hw_int;
    end
  end

  // mfc0 read mux from current register state
  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      CP0_SR:    cp0_out = {16'b0, im_q, 8'b0, exl, ie_q};
      CP0_CAUSE: cp0_out = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b00};
      CP0_EPC:   cp0_out = epc_q;
      CP0_PRID:  cp0_out = PRID_VALUE;
      default:   cp0_out = '0;
    endcase
  end

  // Forward an in-flight EPC write so an eret in the same cycle sees it
  always_comb begin
    epc_out = epc_q;
    if (we && (cp0_addr == CP0_EPC)) begin
      epc_out = cp0_in;
    end
  end

endmodule

// File: tb/tb_m_cp0.sv
// Randomized scoreboard bench for m_cp0 with a register-level reference model.
module tb_m_cp0;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;

  m_cp0 dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .cp0_addr   (cp0_addr),
    .cp0_in     (cp0_in),
    .vpc        (vpc),
    .bd_in      (bd_in),
    .exc_code_in(exc_code_in),
    .hw_int     (hw_int),
    .eret       (eret),
    .cp0_out    (cp0_out),
    .epc_out    (epc_out),
    .req        (req),
    .handler_pc (handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic        req;
    logic [31:0] rd;
    logic [31:0] epc;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: architectural fields
  logic [5:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_bd;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;

  task automatic m_reset();
    m_im = 0; m_ip = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_exc = 0; m_epc = 0;
  endtask

  function automatic logic m_int();
    return ((hw_int & m_im) != 0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_exc_req();
    return (exc_code_in != 0) && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    v = 0;
    if (a == 12) v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
    else if (a == 13) v = (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
    else if (a == 14) v = m_epc;
    else if (a == 15) v = 32'h0042_5541;
    return v;
  endfunction

  // Apply the effect of one rising edge given the inputs that were held across it
  task automatic m_commit();
    logic ir, er;
    logic [31:0] t;
    ir = m_int();
    er = m_exc_req();
    if (ir || er) begin
      m_exl = 1;
      m_exc = ir ? 5'd0 : exc_code_in;
      m_bd  = bd_in;
      t     = bd_in ? vpc - 4 : vpc;
      m_epc = t & 32'hFFFF_FFFC;
    end else begin
      if (we && cp0_addr == 12) begin
        m_im  = cp0_in[15:10];
        m_ie  = cp0_in[0];
        m_exl = cp0_in[1];
      end
      if (we && cp0_addr == 14) m_epc = cp0_in & 32'hFFFF_FFFC;
      if (eret) m_exl = 0;
    end
    m_ip = hw_int;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] pc, input logic b, input logic [4:0] c,
                      input logic [5:0] h, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    m_commit();
    we = w; cp0_addr = a; cp0_in = d; vpc = pc; bd_in = b;
    exc_code_in = c; hw_int = h; eret = e;
    x.req = m_int() || m_exc_req();
    x.rd  = m_read(a);
    x.epc = (w && a == 14) ? d : m_epc;
    sb_q.push_back(x);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    step(0, a, 0, 32'h0000_1000, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are compared mid-cycle against the oldest queued expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("sb_req", 32'(req), 32'(x.req));
        chk("sb_cp0_out", cp0_out, x.rd);
        chk("sb_epc_out", epc_out, x.epc);
      end
    end
  end

  initial begin
    int r;
    logic [4:0] a, c;
    reset = 1; we = 0; cp0_addr = 0; cp0_in = 0; vpc = 0; bd_in = 0;
    exc_code_in = 12; hw_int = 0; eret = 0;
    m_reset();
    #2;
    chk("reset_req", 32'(req), 0);
    cp0_addr = 12; #1 chk("reset_sr", cp0_out, 0);
    cp0_addr = 13; #1 chk("reset_cause", cp0_out, 0);
    cp0_addr = 14; #1 chk("reset_epc", cp0_out, 0);
    chk("handler_pc", handler_pc, 32'h0000_4180);
    exc_code_in = 0;
    @(posedge clk);
    #1 reset = 0;

    rd(15); chk("prid", cp0_out, 32'h0042_5541);
    rd(7);  chk("unmapped", cp0_out, 0);

    // Interrupt taken right after enabling
    step(1, 12, 32'h0000_FC01, 32'h0000_1000, 0, 0, 0, 0);
    step(0, 13, 0, 32'h0000_2000, 0, 0, 6'b000100, 0);
    chk("int_req", 32'(req), 1);
    rd(13); chk("int_exccode", 32'(cp0_out[6:2]), 0);
    rd(12); chk("int_exl", 32'(cp0_out[1]), 1);
    rd(14); chk("int_epc", cp0_out, 32'h0000_2000);
    step(0, 12, 0, 32'h0000_1000, 0, 0, 0, 1);
    rd(12); chk("eret_sr", cp0_out, 32'h0000_FC01);

    // Overflow in a delay slot
    step(0, 13, 0, 32'h0000_3010, 1, 12, 0, 0);
    chk("ov_req", 32'(req), 1);
    rd(14); chk("ov_epc", cp0_out, 32'h0000_300C);
    rd(13); chk("ov_cause", cp0_out, 32'h8000_0030);

    // Exception ignored while in handler
    step(0, 13, 0, 32'h0000_5000, 0, 4, 0, 0);
    chk("exl_block_req", 32'(req), 0);
    rd(13); chk("exl_block_cause", cp0_out, 32'h8000_0030);
    rd(14); chk("exl_block_epc", cp0_out, 32'h0000_300C);

    // EPC forward with eret
    step(1, 14, 32'h0000_3040, 32'h0000_1000, 0, 0, 0, 1);
    chk("epc_fwd", epc_out, 32'h0000_3040);
    rd(12); chk("eret_exl", 32'(cp0_out[1]), 0);

    // Interrupt beats RI, mtc0 discarded
    step(1, 12, 0, 32'h0000_6000, 0, 10, 6'b000001, 0);
    chk("int_ri_req", 32'(req), 1);
    rd(13); chk("int_ri_code", 32'(cp0_out[6:2]), 0);
    rd(12); chk("mtc0_discard", cp0_out, 32'h0000_FC03);

    // Asynchronous reset mid-handler
    @(posedge clk);
    #1;
    m_commit();
    we = 0; cp0_addr = 12; exc_code_in = 12; hw_int = 6'h3F; eret = 0;
    #1 reset = 1;
    #1 chk("areset_sr", cp0_out, 0);
    chk("areset_req", 32'(req), 0);
    cp0_addr = 13; #1 chk("areset_cause", cp0_out, 0);
    cp0_addr = 14; #1 chk("areset_epc", cp0_out, 0);
    @(posedge clk);
    #1 reset = 0;
    exc_code_in = 0; hw_int = 0;
    m_reset();
    rd(12); chk("post_reset_sr", cp0_out, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 8) ? 5'(12 + (r % 4)) : 5'($urandom_range(0, 31));
      r = $urandom_range(0, 9);
      c = (r == 0) ? 5'd4 : (r == 1) ? 5'd5 : (r == 2) ? 5'd10 : (r == 3) ? 5'd12 : 5'd0;
      step($urandom_range(0, 4) == 0, a, $urandom, $urandom, 1'($urandom_range(0, 1)), c,
           ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0, $urandom_range(0, 5) == 0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
